// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit.
// Build option: MULDIV_FAST_ZERO_EN short-circuits divide-by-zero and signed overflow.
package ex_muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } md_state_t;

  function automatic logic md_rs1_signed(input logic [2:0] f);
    return (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
  endfunction

  function automatic logic md_rs2_signed(input logic [2:0] f);
    return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or
// restoring-division step, both working on operand magnitudes.
module ex_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              i_is_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_rem,
  input  logic [XLEN-1:0]   i_opb,
  output logic [2*XLEN-1:0] o_acc,
  output logic [XLEN-1:0]   o_rem
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign w_sum = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opb} : '0);

  // Divide: acc low half shifts dividend bits out and quotient bits in.
  assign w_shift = {i_rem, i_acc[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, i_opb});
  assign w_diff  = w_shift[XLEN-1:0] - i_opb;

  always_comb begin
    o_acc = i_acc;
    o_rem = i_rem;
    if (i_is_div) begin
      o_acc = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-2:0], w_ge};
      o_rem = w_ge ? w_diff : w_shift[XLEN-1:0];
    end else begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative RV32M unit: FSM, counter, sign capture and sign fixup.
// Build option: MULDIV_FAST_ZERO_EN sends divide-by-zero/overflow straight to DONE.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   md_start,
  input  logic [2:0]             md_funct,
  input  logic [XLEN-1:0]        read_data1,
  input  logic [XLEN-1:0]        read_data2,
  input  logic [RFIDX_WIDTH-1:0] rd_index,
  input  logic                   flush,
  output logic                   md_stall,
  output logic                   md_busy,
  output logic                   md_done,
  output logic [XLEN-1:0]        md_result,
  output logic [RFIDX_WIDTH-1:0] md_rd_index
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t r_state, w_state_next;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_funct;
  logic [RFIDX_WIDTH-1:0] r_rd, r_rd_out;
  logic                   r_s1, r_s2, r_div0, r_ovf;
  logic [2*XLEN-1:0]      r_acc;
  logic [XLEN-1:0]        r_rem, r_opb, r_result;

  logic              w_accept, w_s1, w_s2, w_div0, w_ovf, w_fast;
  logic [XLEN-1:0]   w_mag1, w_mag2, w_fast_result, w_quo, w_remd, w_fix_result;
  logic [2*XLEN-1:0] w_prod, w_acc_step;
  logic [XLEN-1:0]   w_rem_step;

  assign w_accept = (r_state == ST_IDLE) && md_start && !flush;
  assign w_s1     = read_data1[XLEN-1] && md_rs1_signed(md_funct);
  assign w_s2     = read_data2[XLEN-1] && md_rs2_signed(md_funct);
  assign w_mag1   = w_s1 ? -read_data1 : read_data1;
  assign w_mag2   = w_s2 ? -read_data2 : read_data2;
  assign w_div0   = (read_data2 == '0);
  assign w_ovf    = md_funct[2] && !md_funct[0] && (read_data1 == XMIN) && (&read_data2);

`ifdef MULDIV_FAST_ZERO_EN
  assign w_fast = md_funct[2] && (w_div0 || w_ovf);
`else
  assign w_fast = 1'b0;
`endif
  assign w_fast_result = md_funct[1] ? (w_div0 ? read_data1 : '0)
                                     : (w_div0 ? '1 : read_data1);

  ex_muldiv_step #(.XLEN(XLEN)) u_step (
    .i_is_div (r_funct[2]),
    .i_acc    (r_acc),
    .i_rem    (r_rem),
    .i_opb    (r_opb),
    .o_acc    (w_acc_step),
    .o_rem    (w_rem_step)
  );

  // Sign correction; divide-by-zero and overflow quotients are forced explicitly.
  assign w_prod = (r_s1 ^ r_s2) ? -r_acc : r_acc;
  assign w_quo  = r_div0 ? '1 : r_ovf ? XMIN :
                  ((r_s1 ^ r_s2) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0]);
  assign w_remd = r_ovf ? '0 : (r_s1 ? -r_rem : r_rem);

  always_comb begin
    w_fix_result = w_prod[XLEN-1:0];
    case (r_funct)
      MD_MUL:                     w_fix_result = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_fix_result = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:            w_fix_result = w_quo;
      default:                    w_fix_result = w_remd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    md_stall     = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        md_stall     = 1'b1;
        w_state_next = w_fast ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        md_stall = 1'b1;
        if (r_cnt == CNT_LAST) w_state_next = ST_FIXUP;
      end
      ST_FIXUP: begin
        md_stall     = 1'b1;
        w_state_next = ST_DONE;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (flush) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_funct  <= '0;
      r_rd     <= '0;
      r_rd_out <= '0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_opb    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_funct <= md_funct;
      r_rd    <= rd_index;
      r_s1    <= w_s1;
      r_s2    <= w_s2;
      r_div0  <= md_funct[2] && w_div0;
      r_ovf   <= w_ovf;
      r_acc   <= {{XLEN{1'b0}}, w_mag1};
      r_rem   <= '0;
      r_opb   <= w_mag2;
      if (w_fast) begin
        r_result <= w_fast_result;
        r_rd_out <= rd_index;
      end
    end else if (r_state == ST_CALC) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      r_acc <= w_acc_step;
      r_rem <= w_rem_step;
    end else if (r_state == ST_FIXUP && !flush) begin
      r_result <= w_fix_result;
      r_rd_out <= r_rd;
    end
  end

  assign md_busy     = (r_state != ST_IDLE);
  assign md_done     = (r_state == ST_DONE);
  assign md_result   = r_result;
  assign md_rd_index = r_rd_out;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized self-checking bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        md_start = 1'b0;
  logic [2:0]  md_funct = '0;
  logic [31:0] read_data1 = '0;
  logic [31:0] read_data2 = '0;
  logic [4:0]  rd_index = '0;
  logic        flush = 1'b0;
  logic        md_stall, md_busy, md_done;
  logic [31:0] md_result;
  logic [4:0]  md_rd_index;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .RFIDX_WIDTH(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .md_start    (md_start),
    .md_funct    (md_funct),
    .read_data1  (read_data1),
    .read_data2  (read_data2),
    .rd_index    (rd_index),
    .flush       (flush),
    .md_stall    (md_stall),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .md_result   (md_result),
    .md_rd_index (md_rd_index)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_ZERO_EN
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`endif
    return 34;
  endfunction

  // Called at a falling edge: drives the instruction into ID/EX for this cycle.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    md_start   = 1'b1;
    md_funct   = f;
    read_data1 = a;
    read_data2 = b;
    rd_index   = rd;
    #1;
  endtask

  task automatic wait_done(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] exp;
    int lat, cyc, stall_cnt;
    bit got;
    exp = ref_md(f, a, b);
    lat = exp_latency(f, a, b);
    cyc = 0; stall_cnt = 0; got = 0;
    check("stall_accept", {31'b0, md_stall}, 32'd1);
    while (cyc < 100 && !got) begin
      @(negedge clk);
      cyc++;
      if (md_done) got = 1;
      else if (md_stall) stall_cnt++;
    end
    md_start = 1'b0;
    #1;
    if (!got) check("done_timeout", 32'd0, 32'd1);
    check("latency", cyc, lat);
    check("stall_cycles", stall_cnt, lat - 1);
    check("stall_in_done", {31'b0, md_stall}, 32'd0);
    check("result", md_result, exp);
    check("rd_index", {27'b0, md_rd_index}, {27'b0, rd});
    $display("op f=%0d a=%h b=%h rd=%0d result=%h expected=%h latency=%0d", f, a, b, rd, md_result, exp, cyc);
    @(negedge clk);
    check("done_pulse", {31'b0, md_done}, 32'd0);
    check("result_hold", md_result, exp);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    issue(f, a, b, rd);
    wait_done(f, a, b, rd);
  endtask

  typedef struct { logic [2:0] f; logic [31:0] a; logic [31:0] b; } vec_t;
  vec_t dir[$];

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;

    #1;
    check("rst_busy",   {31'b0, md_busy},  32'd0);
    check("rst_done",   {31'b0, md_done},  32'd0);
    check("rst_stall",  {31'b0, md_stall}, 32'd0);
    check("rst_result", md_result, 32'd0);
    check("rst_rd",     {27'b0, md_rd_index}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    dir.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD});
    dir.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000});
    dir.push_back('{3'd3, 32'h8000_0000,  32'h8000_0000});
    dir.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF});
    dir.push_back('{3'd5, 32'd100,        32'd7});
    dir.push_back('{3'd7, 32'd100,        32'd7});
    dir.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2});
    dir.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2});
    dir.push_back('{3'd4, 32'd5,          32'd0});
    dir.push_back('{3'd6, 32'd5,          32'd0});
    dir.push_back('{3'd4, 32'hFFFF_FFFB,  32'd0});
    dir.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF});
    dir.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF});
    dir.push_back('{3'd5, 32'h8000_0000,  32'hFFFF_FFFF});
    foreach (dir[i]) run_op(dir[i].f, dir[i].a, dir[i].b, 5'(i + 1));

    // Flush ten cycles after acceptance, then a fresh op in the following cycle.
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    md_start = 1'b0;
    #1;
    check("flush_busy",  {31'b0, md_busy},  32'd0);
    check("flush_stall", {31'b0, md_stall}, 32'd0);
    check("flush_done",  {31'b0, md_done},  32'd0);
    run_op(3'd5, 32'd1000, 32'd33, 5'd10);

    // Asynchronous reset in the middle of an op, start held high across release.
    issue(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd11);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   {31'b0, md_busy}, 32'd0);
    check("mid_rst_done",   {31'b0, md_done}, 32'd0);
    check("mid_rst_result", md_result, 32'd0);
    check("mid_rst_rd",     {27'b0, md_rd_index}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd11);
    wait_done(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd11);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(f, a, b, 5'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
